// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the single-clock flagged FIFO.
// Holds the read-mode enum, width helper and default thresholds.
package sync_fifo_pkg;

  typedef enum logic {
    ModeStd  = 1'b0,
    ModeFwft = 1'b1
  } read_mode_e;

  localparam int unsigned DefDsize     = 8;
  localparam int unsigned DefAsize     = 9;
  localparam int unsigned DefAemptyLvl = 4;
  localparam int unsigned DefAfullGap  = 4;

  // count must represent 0..2**asize inclusive
  function automatic int unsigned cnt_width(input int unsigned asize);
    return asize + 1;
  endfunction

  function automatic int unsigned afull_default(input int unsigned asize);
    return (1 << asize) - DefAfullGap;
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer handshake and status bundle for sync_fifo_flags.
// The slave modport is the FIFO side; master is the user side.
interface sync_fifo_flags_if #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 9
) ();

  logic             w_inc;
  logic [DSIZE-1:0] wdata;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             clr_err;
  logic             w_full;
  logic             rempty;
  logic             w_afull;
  logic             r_aempty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output w_inc, wdata, rinc, clr_err,
    input  rdata, w_full, rempty, w_afull, r_aempty, count, overflow, underflow
  );

  modport slave (
    input  w_inc, wdata, rinc, clr_err,
    output rdata, w_full, rempty, w_afull, r_aempty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifomem.sv
// FIFO storage: 2**ASIZE x DSIZE array, synchronous write, asynchronous read.
module sync_fifomem #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 9
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << ASIZE;

  logic [DSIZE-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact count, programmable thresholds, sticky errors
// and a compile-time choice of registered or first-word-fall-through reads.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE      = DefDsize,
  parameter int unsigned ASIZE      = DefAsize,
  parameter int unsigned AFULL_LVL  = afull_default(ASIZE),
  parameter int unsigned AEMPTY_LVL = DefAemptyLvl,
  parameter int unsigned FWFT       = 0
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_flags_if.slave bus_io
);

  localparam int unsigned Depth = 1 << ASIZE;
  localparam int unsigned CntW  = cnt_width(ASIZE);
  localparam read_mode_e  Mode  = (FWFT != 0) ? ModeFwft : ModeStd;

  if (AFULL_LVL < 1 || AFULL_LVL > Depth) begin : g_bad_afull
    $fatal(1, "sync_fifo_flags: AFULL_LVL out of range");
  end
  if (AEMPTY_LVL >= Depth) begin : g_bad_aempty
    $fatal(1, "sync_fifo_flags: AEMPTY_LVL out of range");
  end

  logic [ASIZE-1:0] waddr_q, waddr_d;
  logic [ASIZE-1:0] raddr_q, raddr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [DSIZE-1:0] mem_rdata;
  logic             full, empty, wr_acc, rd_acc;

  assign full   = (count_q == CntW'(Depth));
  assign empty  = (count_q == '0);
  assign wr_acc = bus_io.w_inc && !full;
  assign rd_acc = bus_io.rinc && !empty;

  always_comb begin
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    count_d     = count_q;
    rdata_d     = rdata_q;
    if (wr_acc) waddr_d = waddr_q + ASIZE'(1);
    if (rd_acc) begin
      raddr_d = raddr_q + ASIZE'(1);
      rdata_d = mem_rdata;
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // a new error event outranks a simultaneous clear
    overflow_d  = (bus_io.w_inc && full) || (overflow_q && !bus_io.clr_err);
    underflow_d = (bus_io.rinc && empty) || (underflow_q && !bus_io.clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q     <= '0;
      raddr_q     <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifomem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (waddr_q),
    .wdata_i (bus_io.wdata),
    .raddr_i (raddr_q),
    .rdata_o (mem_rdata)
  );

  assign bus_io.rdata     = (Mode == ModeFwft) ? mem_rdata : rdata_q;
  assign bus_io.w_full    = full;
  assign bus_io.rempty    = empty;
  assign bus_io.w_afull   = (count_q >= CntW'(AFULL_LVL));
  assign bus_io.r_aempty  = (count_q <= CntW'(AEMPTY_LVL));
  assign bus_io.count     = count_q;
  assign bus_io.overflow  = overflow_q;
  assign bus_io.underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and
// checks both against a queue-based model every cycle.
module tb_sync_fifo_flags;

  localparam int unsigned Dw    = 8;
  localparam int unsigned Aw    = 4;
  localparam int unsigned Depth = 16;
  localparam int unsigned AFull = 12;
  localparam int unsigned AEmpt = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_inc, rinc, clr_err;
  logic [Dw-1:0] wdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [Dw-1:0] q[$];
  logic [Dw-1:0] m_rd;
  bit            m_ov, m_un;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DSIZE(Dw), .ASIZE(Aw)) if_std ();
  sync_fifo_flags_if #(.DSIZE(Dw), .ASIZE(Aw)) if_fwft ();

  assign if_std.w_inc    = w_inc;
  assign if_std.wdata    = wdata;
  assign if_std.rinc     = rinc;
  assign if_std.clr_err  = clr_err;
  assign if_fwft.w_inc   = w_inc;
  assign if_fwft.wdata   = wdata;
  assign if_fwft.rinc    = rinc;
  assign if_fwft.clr_err = clr_err;

  sync_fifo_flags #(
    .DSIZE(Dw), .ASIZE(Aw), .AFULL_LVL(AFull), .AEMPTY_LVL(AEmpt), .FWFT(0)
  ) u_std (
    .clk    (clk),
    .rst    (rst),
    .bus_io (if_std)
  );

  sync_fifo_flags #(
    .DSIZE(Dw), .ASIZE(Aw), .AFULL_LVL(AFull), .AEMPTY_LVL(AEmpt), .FWFT(1)
  ) u_fwft (
    .clk    (clk),
    .rst    (rst),
    .bus_io (if_fwft)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit w, input logic [Dw-1:0] d, input bit r,
                            input bit c, input bit rs);
    bit was_full, was_empty;
    if (rs) begin
      q.delete();
      m_rd = '0;
      m_ov = 0;
      m_un = 0;
    end else begin
      was_full  = (q.size() == Depth);
      was_empty = (q.size() == 0);
      if (r && !was_empty) m_rd = q.pop_front();
      if (w && !was_full) q.push_back(d);
      m_ov = (w && was_full) || (m_ov && !c);
      m_un = (r && was_empty) || (m_un && !c);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("std_count",    32'(if_std.count),     32'(n));
    chk("std_full",     32'(if_std.w_full),    32'(n == Depth));
    chk("std_empty",    32'(if_std.rempty),    32'(n == 0));
    chk("std_afull",    32'(if_std.w_afull),   32'(n >= AFull));
    chk("std_aempty",   32'(if_std.r_aempty),  32'(n <= AEmpt));
    chk("std_ovf",      32'(if_std.overflow),  32'(m_ov));
    chk("std_unf",      32'(if_std.underflow), 32'(m_un));
    chk("std_rdata",    32'(if_std.rdata),     32'(m_rd));
    chk("fwft_count",   32'(if_fwft.count),    32'(n));
    chk("fwft_empty",   32'(if_fwft.rempty),   32'(n == 0));
    chk("fwft_full",    32'(if_fwft.w_full),   32'(n == Depth));
    chk("fwft_unf",     32'(if_fwft.underflow), 32'(m_un));
    if (n > 0) chk("fwft_rdata", 32'(if_fwft.rdata), 32'(q[0]));
  endtask

  task automatic cycle(input bit w, input logic [Dw-1:0] d, input bit r,
                       input bit c, input bit rs);
    w_inc   = w;
    wdata   = d;
    rinc    = r;
    clr_err = c;
    rst     = rs;
    @(posedge clk);
    model_step(w, d, r, c, rs);
    #1;
    check_all();
  endtask

  task automatic rand_phase(input int cycles, input int pw, input int pr,
                            input int pc, input int prst);
    for (int i = 0; i < cycles; i++) begin
      cycle($urandom_range(99) < pw, Dw'($urandom), $urandom_range(99) < pr,
            $urandom_range(99) < pc, $urandom_range(999) < prst);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    w_inc = 0; rinc = 0; clr_err = 0; wdata = '0; rst = 1;

    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("lit_rst_count",  32'(if_std.count),    0);
    chk("lit_rst_empty",  32'(if_std.rempty),   1);
    chk("lit_rst_aempty", 32'(if_std.r_aempty), 1);
    chk("lit_rst_full",   32'(if_std.w_full),   0);
    chk("lit_rst_afull",  32'(if_std.w_afull),  0);
    chk("lit_rst_rdata",  32'(if_std.rdata),    0);
    chk("lit_rst_ovf",    32'(if_std.overflow), 0);
    chk("lit_rst_unf",    32'(if_std.underflow), 0);

    for (int i = 0; i < 16; i++) begin
      cycle(1, Dw'(i), 0, 0, 0);
      if (i == 3)  chk("lit_aempty_at4", 32'(if_std.r_aempty), 1);
      if (i == 4)  chk("lit_aempty_at5", 32'(if_std.r_aempty), 0);
      if (i == 10) chk("lit_afull_at11", 32'(if_std.w_afull),  0);
      if (i == 11) chk("lit_afull_at12", 32'(if_std.w_afull),  1);
      if (i == 14) chk("lit_full_at15",  32'(if_std.w_full),   0);
    end
    chk("lit_full_at16",  32'(if_std.w_full), 1);
    chk("lit_count16",    32'(if_std.count),  16);
    chk("lit_model16",    32'(q.size()),      16);

    cycle(1, 8'hEE, 0, 0, 0);
    chk("lit_ovf_set",    32'(if_std.overflow), 1);
    chk("lit_ovf_count",  32'(if_std.count),    16);
    cycle(0, 0, 0, 0, 0);
    chk("lit_ovf_sticky", 32'(if_std.overflow), 1);

    cycle(1, 8'h77, 1, 0, 0);
    chk("lit_rw_full_count", 32'(if_std.count), 15);
    chk("lit_rw_full_rdata", 32'(if_std.rdata), 0);

    for (int i = 1; i < 16; i++) begin
      cycle(0, 0, 1, 0, 0);
      chk("lit_drain_rdata", 32'(if_std.rdata), 32'(i));
    end
    chk("lit_drain_empty", 32'(if_std.rempty), 1);

    cycle(0, 0, 1, 0, 0);
    chk("lit_unf_set",   32'(if_std.underflow), 1);
    chk("lit_unf_hold",  32'(if_std.rdata),     32'h0F);
    cycle(0, 0, 1, 1, 0);
    chk("lit_set_wins",  32'(if_std.underflow), 1);
    chk("lit_ovf_clr",   32'(if_std.overflow),  0);
    cycle(0, 0, 0, 1, 0);
    chk("lit_unf_clr",   32'(if_std.underflow), 0);

    cycle(1, 8'hA5, 1, 0, 0);
    chk("lit_rw_empty_count", 32'(if_std.count),   1);
    chk("lit_fwft_a5",        32'(if_fwft.rdata),  32'hA5);
    chk("lit_fwft_nonempty",  32'(if_fwft.rempty), 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0);
    chk("lit_fwft_pop_empty", 32'(if_fwft.rempty), 1);
    chk("lit_std_a5",         32'(if_std.rdata),   32'hA5);

    for (int i = 0; i < 7; i++) cycle(1, Dw'(8'h30 + i), 0, 0, 0);
    cycle(1, 8'h40, 1, 0, 0);
    chk("lit_rw7_count", 32'(if_std.count),  7);
    chk("lit_rw7_std",   32'(if_std.rdata),  32'h30);
    chk("lit_rw7_fwft",  32'(if_fwft.rdata), 32'h31);

    rand_phase(40, 50, 50, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) cycle(0, 0, 1, 0, 0);
    chk("lit_drained", 32'(if_std.count), 0);
    for (int i = 0; i < 9; i++) cycle(1, Dw'($urandom), 0, 0, 0);
    chk("lit_count9", 32'(if_std.count), 9);
    cycle(1, 8'h11, 1, 0, 1);
    chk("lit_midrst_count", 32'(if_std.count),  0);
    chk("lit_midrst_empty", 32'(if_std.rempty), 1);

    rand_phase(300, 85, 30, 3, 2);
    rand_phase(300, 30, 85, 3, 2);
    rand_phase(400, 55, 55, 5, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Single-clock, parametrised FIFO for blocks whose producer and consumer share one clock, so no Gray-code pointer synchronisers are needed. It extends the existing FIFO family with:
- programmable almost-full and almost-empty thresholds,
- an exact fill count,
- sticky overflow and underflow error flags,
- a compile-time choice of standard (registered) or first-word-fall-through read mode.

It sits between a same-clock producer and consumer inside a datapath.

## Interface
Parameters:
- DSIZE, 8, data width in bits
- ASIZE, 9, address width; depth = 2**ASIZE
- AFULL_LVL, 2**ASIZE-4, w_afull asserts when count >= AFULL_LVL
- AEMPTY_LVL, 4, r_aempty asserts when count <= AEMPTY_LVL
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  single clock; all logic on rising edge
  - rst  in  1  synchronous, active-high reset
- Write side:
  - w_inc  in  1  write request
  - wdata  in  DSIZE  write data
- Read side:
  - rinc  in  1  read request
  - rdata  out  DSIZE  read data
- Error control:
  - clr_err  in  1  clears the sticky error flags
- Status outputs:
  - w_full  out  1  count == 2**ASIZE
  - rempty  out  1  count == 0
  - w_afull  out  1  count >= AFULL_LVL
  - r_aempty  out  1  count <= AEMPTY_LVL
  - count  out  ASIZE+1  current fill level
  - overflow  out  1  sticky: a write was attempted while full
  - underflow  out  1  sticky: a read was attempted while empty

## Operation
- Accepted write: w_inc && !w_full.
  - wdata is stored at waddr; waddr increments modulo 2**ASIZE.
- Accepted read: rinc && !rempty.
  - raddr increments modulo 2**ASIZE.
- count is a registered ASIZE+1-bit value:
  - +1 on a write only, −1 on a read only, unchanged when both or neither occur.
- Simultaneous requests:
  - When full: the read is accepted and the write is rejected. Count drops by 1.
  - When empty: the write is accepted and the read is rejected. Count rises by 1.
  - In any other state: both are accepted and count is unchanged.
- Rejected requests never modify memory, pointers or count.
- overflow is set on w_inc && w_full.
- underflow is set on rinc && rempty.
  - In FWFT mode, underflow uses the same rule.
- Error flags are cleared only by rst or clr_err.
  - If clr_err and a new error event occur in the same cycle, the flag is set (set wins).
- All flags are decoded combinationally from the registered count, so they are glitch-free relative to clk.
- Standard mode (FWFT=0):
  - rdata is a register loaded with mem[raddr] on an accepted read.
  - Otherwise rdata holds its value.
- FWFT mode (FWFT=1):
  - rdata = mem[raddr] continuously.
  - rdata is valid whenever !rempty; rinc acknowledges and pops the head word.
- Wrap-around: the pointers wrap naturally. count alone distinguishes full from empty.
- AFULL_LVL and AEMPTY_LVL are checked at elaboration:
  - 1 <= AFULL_LVL <= 2**ASIZE
  - 0 <= AEMPTY_LVL < 2**ASIZE
  - Out-of-range values are a fatal elaboration error.

## Timing
- Reset values, applied on the rising clk edge with rst=1:
  - pointers = 0, count = 0, rdata = 0
  - rempty = 1, r_aempty = 1
  - w_full = 0, w_afull = 0
  - overflow = 0, underflow = 0
- rst has priority over all other inputs.
  - Reset mid-operation discards the contents: the FIFO is empty the next cycle.
  - Memory contents are not cleared.
- Flag latency:
  - Write at edge N → rempty falls, count increments and thresholds update after edge N (visible in cycle N+1).
  - Read at edge N → w_full falls after edge N.
- Standard mode read latency: rinc accepted at edge N → rdata valid after edge N.
- FWFT latency: the first word written at edge N appears on rdata with rempty=0 in cycle N+1.
- Back-to-back: one write and one read per cycle are sustained indefinitely, at any fill level other than the full and empty boundaries.

## Structure
- Package sync_fifo_pkg holds:
  - the read-mode enumeration (STD, FWFT),
  - a count-width helper function,
  - the default threshold constants.
- Sub-module sync_fifomem holds the storage:
  - 2**ASIZE x DSIZE array,
  - synchronous write,
  - asynchronous read port (the standard-mode output register lives in the top).
- The top holds the pointers, count, flag decode and error flags. No FSM is needed; the control state is the pointer and count registers.

## Test plan
- Reset then idle: rst for 2 cycles → count=0, rempty=1, r_aempty=1, w_full=0, w_afull=0, rdata=0, overflow=0, underflow=0.
- Fill and drain (ASIZE=4, AFULL_LVL=12, AEMPTY_LVL=4, FWFT=0):
  - Write 0x00..0x0F → w_afull rises the cycle after the 12th write; w_full the cycle after the 16th.
  - Read 16 → rdata = 0x00..0x0F in order; rempty rises after the 16th read.
- Overflow and underflow:
  - Write while full → no pointer change; overflow=1 and stays set.
  - Read while empty → underflow=1.
  - Pulse clr_err → both flags return to 0.
- Simultaneous read and write:
  - At count=16 → count=15, write dropped.
  - At count=0 → count=1, read dropped.
  - At count=7 → count=7, data order preserved.
- FWFT=1:
  - Write 0xA5 → rdata=0xA5 and rempty=0 the next cycle, with no rinc.
  - rinc → rempty=1.
- Wrap and reset mid-stream:
  - 40 interleaved writes and reads (ASIZE=4) → order preserved across pointer wrap.
  - Assert rst at count=9 → count=0 and rempty=1 the next cycle.
